// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute ALU: operation codes matching
// the ALU control decoder, the FSM state type and the multiplier iteration count.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MULT = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd12;

    localparam int MULT_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mult.sv
// Iterative signed shift-add multiplier: magnitudes are multiplied one bit per
// cycle, and the sign is applied to the final sum as it is handed out.
module alu_seq_mult
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(MULT_ITER);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               neg_q;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] product;

    assign abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    // The last add is taken combinationally so the product is ready in the
    // same cycle the counter reaches its final iteration.
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product  = neg_q ? (~acc_next + 1'b1) : acc_next;
    assign done     = busy_q && (cnt_q == CW'(MULT_ITER - 1));
    assign hi       = product[2*WIDTH-1:WIDTH];
    assign lo       = product[WIDTH-1:0];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, abs_a};
            mplier_q <= abs_b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
        end else if (busy_q) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU with valid/ready handshakes on both sides.
// Define ALU_MULT_EN to include the iterative signed MULT unit and HI result.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_in_0,
    input  logic [WIDTH-1:0] alu_in_1,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] op_res;
    logic             op_ovf;
    logic             op_ill;

`ifdef ALU_MULT_EN
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             mult_start;
    logic             mult_done;
    logic [WIDTH-1:0] mult_hi;
    logic [WIDTH-1:0] mult_lo;

    alu_seq_mult #(
        .WIDTH(WIDTH)
    ) u_mult (
        .clk   (clk),
        .arst_n(arst_n),
        .start (mult_start),
        .a     (alu_in_0),
        .b     (alu_in_1),
        .done  (mult_done),
        .hi    (mult_hi),
        .lo    (mult_lo)
    );

    assign result_hi = result_hi_q;
`else
    assign result_hi = '0;
`endif

    assign sum  = alu_in_0 + alu_in_1;
    assign diff = alu_in_0 - alu_in_1;

    // Single-cycle datapath; MULT lands in the illegal default here and is
    // intercepted by the FSM when the multiplier is built in.
    always_comb begin
        op_res = '0;
        op_ovf = 1'b0;
        op_ill = 1'b0;
        case (alu_control)
            OP_AND: op_res = alu_in_0 & alu_in_1;
            OP_OR:  op_res = alu_in_0 | alu_in_1;
            OP_NOR: op_res = ~(alu_in_0 | alu_in_1);
            OP_ADD: begin
                op_res = sum;
                op_ovf = (alu_in_0[WIDTH-1] == alu_in_1[WIDTH-1]) &&
                         (sum[WIDTH-1] != alu_in_0[WIDTH-1]);
            end
            OP_SUB: begin
                op_res = diff;
                op_ovf = (alu_in_0[WIDTH-1] != alu_in_1[WIDTH-1]) &&
                         (diff[WIDTH-1] != alu_in_0[WIDTH-1]);
            end
            OP_SLL: op_res = alu_in_1 << shamt;
            OP_SRL: op_res = alu_in_1 >> shamt;
            OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(alu_in_0) < $signed(alu_in_1))};
            default: op_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
`ifdef ALU_MULT_EN
        result_hi_d = result_hi_q;
        mult_start  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_MULT_EN
                    if (alu_control == OP_MULT) begin
                        mult_start = 1'b1;
                        state_d    = MUL;
                    end else begin
                        result_hi_d = '0;
`else
                    begin
`endif
                        result_d   = op_res;
                        zero_d     = (op_res == '0);
                        overflow_d = op_ovf;
                        illegal_d  = op_ill;
                        state_d    = DONE;
                    end
                end
            end
`ifdef ALU_MULT_EN
            MUL: begin
                if (mult_done) begin
                    result_d    = mult_lo;
                    result_hi_d = mult_hi;
                    zero_d      = (mult_lo == '0);
                    overflow_d  = 1'b0;
                    illegal_d   = 1'b0;
                    state_d     = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef ALU_MULT_EN
            result_hi_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
`ifdef ALU_MULT_EN
            result_hi_q <= result_hi_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed scenarios plus random operations
// checked against an arithmetic reference model.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] alu_in_0;
    logic [31:0] alu_in_1;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_control(alu_control),
        .alu_in_0   (alu_in_0),
        .alu_in_1   (alu_in_1),
        .shamt      (shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_hi  (result_hi),
        .zero       (zero),
        .overflow   (overflow),
        .illegal    (illegal)
    );

    // Reference: signed 64-bit arithmetic; overflow means the true result does
    // not fit back into 32 signed bits.
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] r, output logic [31:0] rh,
                                  output logic ov, output logic il);
        longint sa;
        longint sb;
        longint t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        t  = 0;
        r  = 32'd0;
        rh = 32'd0;
        ov = 1'b0;
        il = 1'b0;
        case (c)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd12: r = ~(a | b);
            4'd2: begin
                t  = sa + sb;
                r  = t[31:0];
                ov = (t != longint'($signed(t[31:0])));
            end
            4'd5: begin
                t  = sa - sb;
                r  = t[31:0];
                ov = (t != longint'($signed(t[31:0])));
            end
            4'd3:  r = b << sh;
            4'd4:  r = b >> sh;
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_MULT_EN
            4'd8: begin
                t  = sa * sb;
                r  = t[31:0];
                rh = t[63:32];
            end
`endif
            default: il = 1'b1;
        endcase
    endfunction

    // Issue one operation, then scribble on the inputs while waiting for the
    // result; lat counts edges from the accepting edge (1 = visible right after it).
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, output int lat, output bit ir_high);
        @(negedge clk);
        in_valid    = 1'b1;
        alu_control = c;
        alu_in_0    = a;
        alu_in_1    = b;
        shamt       = sh;
        @(posedge clk);
        #1;
        alu_control = 4'($urandom);
        alu_in_0    = $urandom;
        alu_in_1    = $urandom;
        shamt       = 5'($urandom);
        lat         = -1;
        ir_high     = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            if (in_ready) ir_high = 1'b1;
            @(posedge clk);
            #1;
        end
        if (in_ready) ir_high = 1'b1;
    endtask

    task automatic release_out();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        arst_n      = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        alu_control = 4'd0;
        alu_in_0    = 32'd0;
        alu_in_1    = 32'd0;
        shamt       = 5'd0;
        #12;
        total++;
        if ({out_valid, result, result_hi, zero, overflow, illegal, in_ready} !==
            {1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b r=%h hi=%h z=%b o=%b i=%b rdy=%b want v=0 r=0 hi=0 z=0 o=0 i=0 rdy=1",
                     out_valid, result, result_hi, zero, overflow, illegal, in_ready);
        end
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_add_overflow();
        int lat;
        bit irh;
        run_op(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, lat, irh);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL add_latency: got %0d want 1", lat); end
        total++;
        if (result !== 32'h8000_0000) begin bad++; $display("FAIL add_result: got %h want 80000000", result); end
        total++;
        if (overflow !== 1'b1 || zero !== 1'b0) begin
            bad++; $display("FAIL add_flags: got ovf=%b zero=%b want ovf=1 zero=0", overflow, zero);
        end
        release_out();
    endtask

    task automatic test_sub_zero_slt();
        int lat;
        bit irh;
        run_op(4'd5, 32'd5, 32'd5, 5'd0, lat, irh);
        total++;
        if (result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL sub_zero: got r=%h z=%b o=%b want r=0 z=1 o=0", result, zero, overflow);
        end
        release_out();
        run_op(4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, lat, irh);
        total++;
        if (result !== 32'd1 || zero !== 1'b0) begin
            bad++; $display("FAIL slt_signed: got r=%h z=%b want r=1 z=0", result, zero);
        end
        release_out();
    endtask

    task automatic test_mult();
`ifdef ALU_MULT_EN
        int lat;
        bit irh;
        run_op(4'd8, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, lat, irh);
        total++;
        if (lat !== 33) begin bad++; $display("FAIL mult_latency: got %0d want 33", lat); end
        total++;
        if (irh !== 1'b0) begin bad++; $display("FAIL mult_in_ready: got high while busy want low"); end
        total++;
        if (result_hi !== 32'hFFFF_FFFF || result !== 32'hFFFF_FFFE || overflow !== 1'b0) begin
            bad++; $display("FAIL mult_value: got hi=%h lo=%h o=%b want hi=ffffffff lo=fffffffe o=0",
                            result_hi, result, overflow);
        end
        release_out();
        run_op(4'd8, 32'h8000_0000, 32'h8000_0000, 5'd0, lat, irh);
        total++;
        if (result_hi !== 32'h4000_0000 || result !== 32'd0 || zero !== 1'b1) begin
            bad++; $display("FAIL mult_minint: got hi=%h lo=%h z=%b want hi=40000000 lo=0 z=1",
                            result_hi, result, zero);
        end
        release_out();
`else
        int lat;
        bit irh;
        run_op(4'd8, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, lat, irh);
        total++;
        if (lat !== 1 || result !== 32'd0 || result_hi !== 32'd0 || illegal !== 1'b1) begin
            bad++; $display("FAIL mult_disabled: got lat=%0d r=%h hi=%h ill=%b want lat=1 r=0 hi=0 ill=1",
                            lat, result, result_hi, illegal);
        end
        release_out();
`endif
    endtask

    task automatic test_backpressure();
        int lat;
        bit irh;
        run_op(4'd3, $urandom, 32'h0000_0001, 5'd31, lat, irh);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL bp_latency: got %0d want 1", lat); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (result !== 32'h8000_0000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d: got r=%h v=%b rdy=%b want r=80000000 v=1 rdy=0",
                                i, result, out_valid, in_ready);
            end
            @(posedge clk);
            #1;
        end
        release_out();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_illegal();
        int lat;
        bit irh;
        run_op(4'd6, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, lat, irh);
        total++;
        if (lat !== 1 || result !== 32'd0 || result_hi !== 32'd0 || illegal !== 1'b1 || zero !== 1'b1) begin
            bad++; $display("FAIL illegal_6: got lat=%0d r=%h hi=%h ill=%b z=%b want lat=1 r=0 hi=0 ill=1 z=1",
                            lat, result, result_hi, illegal, zero);
        end
        release_out();
        run_op(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, lat, irh);
        total++;
        if (result !== 32'd0 || illegal !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL illegal_15: got r=%h ill=%b o=%b want r=0 ill=1 o=0", result, illegal, overflow);
        end
        release_out();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bit irh;
        bit saw_valid;
        @(negedge clk);
        in_valid    = 1'b1;
`ifdef ALU_MULT_EN
        alu_control = 4'd8;
`else
        alu_control = 4'd2;
`endif
        alu_in_0    = 32'd7;
        alu_in_1    = 32'd9;
        shamt       = 5'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, result, result_hi, zero, overflow, illegal, in_ready} !==
            {1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL midreset_outputs: got v=%b r=%h hi=%h z=%b o=%b i=%b rdy=%b want v=0 r=0 hi=0 z=0 o=0 i=0 rdy=1",
                     out_valid, result, result_hi, zero, overflow, illegal, in_ready);
        end
        @(negedge clk);
        arst_n    = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        total++;
        if (saw_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_valid: got out_valid=1 want 0"); end
        run_op(4'd2, 32'd2, 32'd3, 5'd0, lat, irh);
        total++;
        if (lat !== 1 || result !== 32'd5) begin
            bad++; $display("FAIL midreset_add: got lat=%0d r=%h want lat=1 r=5", lat, result);
        end
        release_out();
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'h0000_0001;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h7FFF_FFFF;
            4:       v = 32'h8000_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic test_random();
        logic [3:0]  codes [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd12, 4'd8, 4'd6};
        logic [3:0]  c;
        logic [31:0] a, b, er, eh;
        logic [4:0]  sh;
        logic        eo, ei;
        int          lat, elat;
        bit          irh;
        for (int n = 0; n < 60; n++) begin
            c  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : codes[$urandom_range(0, 9)];
            a  = pick_operand();
            b  = pick_operand();
            sh = 5'($urandom);
            model(c, a, b, sh, er, eh, eo, ei);
            elat = 1;
`ifdef ALU_MULT_EN
            if (c == 4'd8) elat = 33;
`endif
            run_op(c, a, b, sh, lat, irh);
            total++;
            if (lat !== elat || irh !== 1'b0) begin
                bad++; $display("FAIL rnd%0d_timing: code=%0d got lat=%0d rdy_seen=%b want lat=%0d rdy_seen=0",
                                n, c, lat, irh, elat);
            end
            total++;
            if (result !== er || result_hi !== eh) begin
                bad++; $display("FAIL rnd%0d_value: code=%0d a=%h b=%h sh=%0d got hi=%h r=%h want hi=%h r=%h",
                                n, c, a, b, sh, result_hi, result, eh, er);
            end
            total++;
            if (zero !== (er == 32'd0) || overflow !== eo || illegal !== ei) begin
                bad++; $display("FAIL rnd%0d_flags: code=%0d got z=%b o=%b i=%b want z=%b o=%b i=%b",
                                n, c, zero, overflow, illegal, (er == 32'd0), eo, ei);
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_zero_slt();
        test_mult();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
